// File: rtl/abcd_seq_gen_if.sv
// abcd_seq_gen_if: control inputs and protocol/status outputs of the abcd pattern generator
interface abcd_seq_gen_if #(
  parameter int GAP_W = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] n_iter;
  logic [GAP_W-1:0] gap;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter_cnt;
  modport master (
    output start, abort, n_iter, gap,
    input  a, b, c, d, busy, done, iter_cnt
  );
  modport slave (
    input  start, abort, n_iter, gap,
    output a, b, c, d, busy, done, iter_cnt
  );
endinterface

// File: rtl/abcd_seq_gen.sv
// abcd_seq_gen: emits a ##1 b ##1 c ##2 d n_iter times with a gap-cycle idle spacing
module abcd_seq_gen #(
  parameter int GAP_W = 4,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  abcd_seq_gen_if.slave sif
);
  typedef enum logic [2:0] {IDLE, SA, SB, SC, SW, SD, GAP} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d, cnt_q, cnt_d, cnt_inc;
  logic [GAP_W-1:0] g_q, g_d, gc_q, gc_d;
  logic             done_q, done_d;
  assign cnt_inc = cnt_q + CNT_W'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      gc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      gc_q    <= gc_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    gc_d    = gc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (sif.start) begin
        n_d     = sif.n_iter;
        g_d     = sif.gap;
        cnt_d   = '0;
        done_d  = sif.n_iter == '0;
        state_d = sif.n_iter == '0 ? IDLE : SA;
      end
      SA: state_d = SB;
      SB: state_d = SC;
      SC: state_d = SW;
      SW: state_d = SD;
      SD: begin
        cnt_d   = cnt_inc;
        done_d  = cnt_inc == n_q;
        gc_d    = g_q - GAP_W'(1);
        state_d = cnt_inc == n_q ? IDLE : (g_q == '0 ? SA : GAP);
      end
      GAP: begin
        gc_d    = gc_q == '0 ? gc_q : gc_q - GAP_W'(1);
        state_d = gc_q == '0 ? SA : GAP;
      end
      default: state_d = IDLE;
    endcase
    // abort beats everything, including the count bump on SD exit
    if (sif.abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
    end
  end
  assign sif.a        = state_q == SA;
  assign sif.b        = state_q == SB;
  assign sif.c        = state_q == SC;
  assign sif.d        = state_q == SD;
  assign sif.busy     = state_q != IDLE;
  assign sif.done     = done_q;
  assign sif.iter_cnt = cnt_q;
endmodule

// File: tb/tb_abcd_seq_gen.sv
// tb_abcd_seq_gen: random runs against a trace-level model, checked by a per-cycle scoreboard
module tb_abcd_seq_gen;
  typedef struct packed {
    logic [3:0] abcd;
    logic       busy;
    logic       done;
    logic [7:0] iter;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  int exp_iter = 0;
  item_t sb[$];
  logic [3:0] pat [5];
  abcd_seq_gen_if #(.GAP_W(4), .CNT_W(8)) bus ();
  abcd_seq_gen #(.GAP_W(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .sif(bus.slave));
  always #5 clk = ~clk;
  function automatic item_t act_item();
    item_t it;
    it.abcd = {bus.a, bus.b, bus.c, bus.d};
    it.busy = bus.busy;
    it.done = bus.done;
    it.iter = bus.iter_cnt;
    return it;
  endfunction
  task automatic check(input string name, input item_t act, input item_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got abcd=%b busy=%b done=%b iter=%0d want abcd=%b busy=%b done=%b iter=%0d",
               name, $time, act.abcd, act.busy, act.done, act.iter, exp.abcd, exp.busy, exp.done, exp.iter);
    end
  endtask
  function automatic item_t mk(input logic [3:0] abcd, input logic busy, input logic done, input int iter);
    item_t it;
    it.abcd = abcd;
    it.busy = busy;
    it.done = done;
    it.iter = 8'(iter);
    return it;
  endfunction
  initial forever begin
    @(posedge clk);
    #1;
    if (mon_en && sb.size() > 0) check("cycle", act_item(), sb.pop_front());
  end
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      sb.push_back(mk(4'b0000, 1'b0, 1'b0, exp_iter));
      @(negedge clk);
    end
  endtask
  task automatic run(input int n, input int g, input int ab, input bit ign);
    item_t t[$];
    int len;
    for (int k = 0; k < n; k++) begin
      for (int p = 0; p < 5; p++) t.push_back(mk(pat[p], 1'b1, 1'b0, k));
      if (k < n - 1) for (int i = 0; i < g; i++) t.push_back(mk(4'b0000, 1'b1, 1'b0, k + 1));
    end
    t.push_back(mk(4'b0000, 1'b0, 1'b1, n));
    if (ab > 0 && ab < t.size()) begin
      int held;
      held = t[ab-1].iter;
      t = t[0:ab-1];
      t.push_back(mk(4'b0000, 1'b0, 1'b0, held));
    end else ab = 0;
    if (t.size() < 4 || (ab > 0 && ab < 3)) ign = 1'b0;
    exp_iter = t[t.size()-1].iter;
    len = t.size();
    foreach (t[i]) sb.push_back(t[i]);
    bus.n_iter = 8'(n);
    bus.gap    = 4'(g);
    bus.start  = 1'b1;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      bus.start  = ign && c == 3;
      bus.abort  = ab > 0 && c == ab;
      bus.n_iter = 8'($urandom_range(0, 255));
      bus.gap    = 4'($urandom_range(0, 15));
    end
  endtask
  initial begin
    pat = '{4'b1000, 4'b0100, 4'b0010, 4'b0000, 4'b0001};
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.n_iter = '0;
    bus.gap = '0;
    #12;
    check("reset", act_item(), mk(4'b0000, 1'b0, 1'b0, 0));
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);
    run(1, 0, 0, 1'b0);
    idle(1);
    run(2, 2, 0, 1'b0);
    idle(2);
    run(3, 0, 0, 1'b0);
    run(0, 0, 0, 1'b0);
    idle(1);
    run(4, 1, 9, 1'b1);
    idle(2);
    run(2, 1, 0, 1'b1);
    run(1, 3, 0, 1'b0);
    run(2, 0, 10, 1'b0);
    idle(1);
    mon_en = 1'b0;
    bus.n_iter = 8'd2;
    bus.gap = 4'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", act_item(), mk(4'b0000, 1'b0, 1'b0, 0));
    @(negedge clk);
    check("reset_hold", act_item(), mk(4'b0000, 1'b0, 1'b0, 0));
    rst = 1'b0;
    exp_iter = 0;
    mon_en = 1'b1;
    idle(1);
    run(1, 0, 0, 1'b0);
    for (int r = 0; r < 30; r++) begin
      int n, g, ab;
      n  = $urandom_range(0, 5);
      g  = $urandom_range(0, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      run(n, g, ab, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    idle(3);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/abcd_seq_gen.md
# abcd_seq_gen

Synthesizable stimulus generator that drives the four-signal protocol `a ##1 b ##1 c ##2 d`, sampled on `posedge clk`, and repeats it a programmable number of times with a programmable idle gap between repetitions. It sits on the producing side of that protocol, upstream of the concurrent property checker in the assertion benches. The bench or a controller starts it with a single-cycle `start`. It reports progress through `busy`, `done` and `iter_cnt`.

## Interface
- `GAP_W`, default 4: width of the inter-pattern idle-gap field.
- `CNT_W`, default 8: width of the repetition-count field and the completed-pattern counter.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `abort` in 1: synchronous cancel; sampled in every non-IDLE state.
- `n_iter` in CNT_W: number of patterns to emit; captured on accepted `start`.
- `gap` in GAP_W: idle cycles between patterns; captured on accepted `start`.
- `a`, `b`, `c`, `d` out 1 each: protocol outputs, registered.
- `busy` out 1: run in progress, registered.
- `done` out 1: one-cycle completion pulse, registered.
- `iter_cnt` out CNT_W: patterns completed in the current or last run.

## Operation
- States: IDLE, SA, SB, SC, SW, SD, GAP. Outputs are Moore and registered, taken directly from state.
- Output decode per state:
  - SA: `a`=1. SB: `b`=1. SC: `c`=1. SD: `d`=1.
  - All other states: `a`, `b`, `c`, `d` all 0. At most one of them is ever high.
- `busy`=1 in SA, SB, SC, SW, SD and GAP; 0 in IDLE.
- IDLE transitions:
  - IDLE and `start`=1 and `n_iter`≠0 → SA. Latch `n_iter` and `gap`; clear `iter_cnt` to 0.
  - IDLE and `start`=1 and `n_iter`=0 → stay IDLE. `done` pulses on the next edge; `iter_cnt` is cleared to 0.
- Pattern transitions: SA→SB→SC→SW→SD, unconditionally, one cycle each.
- Leaving SD:
  - `iter_cnt` increments on this edge.
  - If `iter_cnt`+1 equals the latched `n_iter` → IDLE, with `done`=1 for exactly one cycle.
  - Otherwise, latched `gap`=0 → SA directly, giving back-to-back patterns.
  - Otherwise, latched `gap`≠0 → GAP with the gap counter loaded to `gap`−1.
- GAP: decrement the counter each cycle; when the counter is 0 → SA. This yields exactly `gap` idle cycles.
- `start` while `busy`=1 is ignored. `n_iter` and `gap` changes mid-run have no effect, because the values were latched.
- `abort`=1 in any non-IDLE state:
  - → IDLE on that edge; all protocol outputs 0 and `busy`=0 from then on.
  - No `done` pulse; `iter_cnt` holds the count of patterns completed so far.
- `abort` has priority over every other transition, including the SD-exit decision.
- `iter_cnt` never wraps: its maximum value is `n_iter`, which is at most 2^CNT_W−1.

## Timing
- Reset values (asynchronous assertion of `rst`): state IDLE; `a`=`b`=`c`=`d`=0, `busy`=0, `done`=0, `iter_cnt`=0, gap counter 0.
- Reset asserted mid-run clears all of the above immediately, without waiting for a clock edge. The first edge after `rst` deasserts is a normal IDLE cycle.
- Latency, with `start` sampled at edge N:
  - `a`=1 sampled at N+1, `b` at N+2, `c` at N+3, nothing at N+4, `d` at N+5.
  - `busy`=1 sampled from N+1.
- One pattern occupies 5 cycles. Pattern k+1 has its `a` at the last `d` edge + `gap` + 1.
- Final pattern: `d` sampled at edge M; `done`=1 and `busy`=0 sampled at M+1; `done`=0 again at M+2.
- The `n_iter`=0 `done` pulse is sampled at N+1, with `busy` remaining 0.
- A `start` sampled in the same cycle as `done`=1 is accepted, because the state is already IDLE.

## Test plan
- Reset then `start` with `n_iter`=1, `gap`=0 at edge 0 → `a`@1, `b`@2, `c`@3, all-low@4, `d`@5, `done`@6, `iter_cnt`=1; the `a ##1 b ##1 c ##2 d` property passes.
- `n_iter`=2, `gap`=2, `start`@0:
  - First pattern at edges 1–5; idle at 6–7.
  - Second pattern: `a`@8, `b`@9, `c`@10, `d`@12.
  - `done`@13, `iter_cnt`=2, `busy` high at 1–12 only.
- `n_iter`=3, `gap`=0 → `a` at edges 1, 6, 11; `d` at edges 5, 10, 15; `done`@16, `iter_cnt`=3.
- `n_iter`=0, `start`@0 → `done`@1 only; `busy` and all protocol outputs stay 0; `iter_cnt`=0.
- `n_iter`=4, `gap`=1:
  - `abort` sampled at edge 9 (inside the second pattern) → from edge 10 all outputs 0, `busy`=0, no `done`, `iter_cnt`=1.
  - Separately, a second `start` at edge 3 is ignored: no change to the sequence.
- `rst` pulsed asynchronously between edges 3 and 4 of a run → outputs 0 immediately; a new `start` after release produces a clean pattern with `iter_cnt` restarting from 0.
